// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared widths, tap coefficients, FSM states and ring-pointer helpers
//            for the time-multiplexed 13-tap symmetric high-pass FIR.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int NTAPS = 13;
    localparam int XW    = 8;
    localparam int CW    = 13;
    localparam int OW    = 14;
    localparam int SHIFT = 6;
    localparam int PTRW  = $clog2(NTAPS);

    localparam logic signed [CW-1:0] FIR_H [NTAPS] = '{
        13'sd10,   13'sd37,   13'sd59,   -13'sd72,  -13'sd477, -13'sd988, 13'sd2863,
        -13'sd988, -13'sd477, -13'sd72,  13'sd59,   13'sd37,   13'sd10
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NTAPS - 1);

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTRW-1:0] ptr_dec(input logic [PTRW-1:0] p);
        return (p == '0) ? PTR_LAST : p - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_slice.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_slice
// Brief    : One MAC step: acc + floor(h*x / 2^SHIFT), wrapping at OW bits.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_slice
    import fir_pkg::*;
(
    input  logic signed [CW-1:0] i_h,
    input  logic signed [XW-1:0] i_x,
    input  logic        [OW-1:0] i_acc,
    output logic        [OW-1:0] o_sum
);

    logic signed [CW+XW-1:0] w_prod;
    logic        [OW-1:0]    w_term;
    logic                    w_unused_bits;

    assign w_prod = i_h * i_x;
    // Arithmetic truncation of the low bits gives floor division for negatives.
    assign w_term = w_prod[SHIFT +: OW];
    assign o_sum  = i_acc + w_term;

    assign w_unused_bits = ^{w_prod[CW+XW-1 : SHIFT+OW], w_prod[SHIFT-1:0]};

endmodule
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_seq
// Brief    : Single-multiplier sequencer for the 13-tap symmetric FIR with
//            valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_seq
    import fir_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Clear,
    input  logic                 In_valid,
    output logic                 In_ready,
    input  logic signed [XW-1:0] Xin,
    output logic                 Out_valid,
    input  logic                 Out_ready,
    output logic signed [OW-1:0] Out,
    output logic                 Busy
);

    fir_state_e              r_state;
    fir_state_e              w_state_nxt;
    logic signed [XW-1:0]    r_buf [NTAPS];
    logic        [PTRW-1:0]  r_wr_ptr;
    logic        [PTRW-1:0]  r_rd_ptr;
    logic        [PTRW-1:0]  r_tap;
    logic        [OW-1:0]    r_acc;
    logic        [OW-1:0]    r_out;
    logic        [OW-1:0]    w_sum;
    logic                    w_accept;

    fir_mac_slice u_mac (
        .i_h   (FIR_H[r_tap]),
        .i_x   (r_buf[r_rd_ptr]),
        .i_acc (r_acc),
        .o_sum (w_sum)
    );

    assign w_accept = In_valid & In_ready;
    assign Out      = r_out;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        In_ready    = 1'b0;
        Out_valid   = 1'b0;
        Busy        = 1'b0;
        case (r_state)
            IDLE: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                Busy = 1'b1;
                if (r_tap == PTR_LAST) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                Out_valid = 1'b1;
                In_ready  = Out_ready;
                if (Out_ready) begin
                    w_state_nxt = In_valid ? ACC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Flush dominates any handshake offered in the same cycle.
        if (Clear) begin
            In_ready    = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_tap    <= '0;
            r_acc    <= '0;
            r_out    <= '0;
        end else if (Clear) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_accept) begin
            // Read pointer starts on the slot just written so tap 0 is newest.
            r_buf[r_wr_ptr] <= Xin;
            r_rd_ptr        <= r_wr_ptr;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
            r_tap           <= '0;
            r_acc           <= '0;
        end else if (r_state == ACC) begin
            r_acc    <= w_sum;
            r_rd_ptr <= ptr_dec(r_rd_ptr);
            if (r_tap == PTR_LAST) begin
                r_out <= w_sum;
            end else begin
                r_tap <= r_tap + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
